// File: rtl/sha256_pkg.sv
// Shared constants and types for the SHA-256 memory engine: round constants,
// initial hash value, FSM state encoding and the 32-bit rotate helper.
package sha256_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ROUNDS,
        ST_ADD,
        ST_WRITE
    } state_t;

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [31:0] IV [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    function automatic logic [31:0] ror(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

endpackage

// File: rtl/sha256_round.sv
// One SHA-256 compression round, purely combinational: (A..H, K, W) -> next A..H.
module sha256_round
    import sha256_pkg::*;
(
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic [31:0] i_c,
    input  logic [31:0] i_d,
    input  logic [31:0] i_e,
    input  logic [31:0] i_f,
    input  logic [31:0] i_g,
    input  logic [31:0] i_h,
    input  logic [31:0] i_k,
    input  logic [31:0] i_w,
    output logic [31:0] o_a,
    output logic [31:0] o_b,
    output logic [31:0] o_c,
    output logic [31:0] o_d,
    output logic [31:0] o_e,
    output logic [31:0] o_f,
    output logic [31:0] o_g,
    output logic [31:0] o_h
);
    logic [31:0] w_sum1, w_ch, w_t1, w_sum0, w_maj, w_t2;

    assign w_sum1 = ror(i_e, 6) ^ ror(i_e, 11) ^ ror(i_e, 25);
    assign w_ch   = (i_e & i_f) ^ (~i_e & i_g);
    assign w_t1   = i_h + w_sum1 + w_ch + i_k + i_w;
    assign w_sum0 = ror(i_a, 2) ^ ror(i_a, 13) ^ ror(i_a, 22);
    assign w_maj  = (i_a & i_b) ^ (i_a & i_c) ^ (i_b & i_c);
    assign w_t2   = w_sum0 + w_maj;

    assign o_a = w_t1 + w_t2;
    assign o_b = i_a;
    assign o_c = i_b;
    assign o_d = i_c;
    assign o_e = i_d + w_t1;
    assign o_f = i_e;
    assign o_g = i_f;
    assign o_h = i_g;

endmodule

// File: rtl/sha256_mem_engine.sv
// SHA-256 engine that streams a word-aligned message from memory, pads it on the fly,
// hashes it one round per cycle and writes the 8-word digest back to memory.
module sha256_mem_engine
    import sha256_pkg::*;
#(
    parameter int ADDR_W    = 16,
    parameter int MAX_WORDS = 1024
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic [$clog2(MAX_WORDS+1)-1:0]   msg_words,
    input  logic [ADDR_W-1:0]                input_addr,
    input  logic [ADDR_W-1:0]                hash_addr,
    output logic [ADDR_W-1:0]                mem_addr,
    output logic                             mem_we,
    output logic [31:0]                      mem_wdata,
    input  logic [31:0]                      mem_rdata,
    output logic                             busy,
    output logic                             done,
    output logic [255:0]                     digest
);
    localparam int N_W   = $clog2(MAX_WORDS + 1);
    localparam int BLK_W = N_W + 1;
    localparam int G_W   = BLK_W + 4;
    localparam logic [N_W-1:0] MAX_N = N_W'(MAX_WORDS);

    state_t              r_state;
    logic [N_W-1:0]      r_n;
    logic [BLK_W-1:0]    r_blk, r_last_blk;
    logic [6:0]          r_cnt;
    logic [ADDR_W-1:0]   r_in_addr, r_hash_addr, r_mem_addr;
    logic                r_mem_we, r_done;
    logic [31:0]         r_mem_wdata;
    logic [255:0]        r_digest;
    logic [31:0]         r_w  [16];
    logic [31:0]         r_wv [8];
    logic [31:0]         r_hv [8];

    logic [N_W-1:0]      w_n_clamp;
    logic [G_W-1:0]      w_blk_sum;
    logic [BLK_W-1:0]    w_last_blk;
    logic [3:0]          w_j_cap;
    logic [G_W-1:0]      w_g_cap, w_g_rd_load, w_g_rd_blk;
    logic [31:0]         w_load_word, w_w_new, w_s0, w_s1;
    logic [31:0]         w_rnd   [8];
    logic [31:0]         w_h_sum [8];

    assign w_n_clamp  = (msg_words > MAX_N) ? MAX_N : msg_words;
    // ceil((n+3)/16) blocks: data words plus the 0x80 marker and the two length words
    assign w_blk_sum  = G_W'(w_n_clamp) + G_W'(18);
    assign w_last_blk = BLK_W'(w_blk_sum >> 4) - BLK_W'(1);

    assign w_j_cap     = 4'(r_cnt - 7'd1);
    assign w_g_cap     = {r_blk, w_j_cap};
    assign w_g_rd_load = {r_blk, 4'(r_cnt + 7'd1)};
    assign w_g_rd_blk  = {r_blk + BLK_W'(1), 4'd0};

    always_comb begin
        w_load_word = 32'd0;
        if (w_g_cap < G_W'(r_n))
            w_load_word = mem_rdata;
        else if (w_g_cap == G_W'(r_n))
            w_load_word = 32'h8000_0000;
        else if (r_blk == r_last_blk && w_j_cap == 4'd15)
            w_load_word = 32'(r_n) << 5;
    end

    // r_w[0] is W(t); the word appended each round is W(t+16)
    assign w_s0    = ror(r_w[1], 7) ^ ror(r_w[1], 18) ^ (r_w[1] >> 3);
    assign w_s1    = ror(r_w[14], 17) ^ ror(r_w[14], 19) ^ (r_w[14] >> 10);
    assign w_w_new = r_w[0] + w_s0 + r_w[9] + w_s1;

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_hsum
            assign w_h_sum[gi] = r_hv[gi] + r_wv[gi];
        end
    endgenerate

    sha256_round u_round (
        .i_a(r_wv[0]), .i_b(r_wv[1]), .i_c(r_wv[2]), .i_d(r_wv[3]),
        .i_e(r_wv[4]), .i_f(r_wv[5]), .i_g(r_wv[6]), .i_h(r_wv[7]),
        .i_k(K[r_cnt[5:0]]), .i_w(r_w[0]),
        .o_a(w_rnd[0]), .o_b(w_rnd[1]), .o_c(w_rnd[2]), .o_d(w_rnd[3]),
        .o_e(w_rnd[4]), .o_f(w_rnd[5]), .o_g(w_rnd[6]), .o_h(w_rnd[7])
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_done      <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_digest    <= '0;
            r_cnt       <= '0;
            r_blk       <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_n         <= w_n_clamp;
                        r_last_blk  <= w_last_blk;
                        r_in_addr   <= input_addr;
                        r_hash_addr <= hash_addr;
                        r_blk       <= '0;
                        r_cnt       <= '0;
                        for (int i = 0; i < 8; i++) begin
                            r_hv[i] <= IV[i];
                            r_wv[i] <= IV[i];
                        end
                        if (w_n_clamp != '0)
                            r_mem_addr <= input_addr;
                        r_state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    // read data lags the address by one cycle, so capture starts at r_cnt=1
                    if (r_cnt != 7'd0) begin
                        for (int i = 0; i < 15; i++)
                            r_w[i] <= r_w[i+1];
                        r_w[15] <= w_load_word;
                    end
                    if (r_cnt < 7'd15 && w_g_rd_load < G_W'(r_n))
                        r_mem_addr <= r_in_addr + ADDR_W'(w_g_rd_load);
                    if (r_cnt == 7'd16) begin
                        r_cnt   <= '0;
                        r_state <= ST_ROUNDS;
                    end else begin
                        r_cnt <= r_cnt + 7'd1;
                    end
                end
                ST_ROUNDS: begin
                    for (int i = 0; i < 8; i++)
                        r_wv[i] <= w_rnd[i];
                    for (int i = 0; i < 15; i++)
                        r_w[i] <= r_w[i+1];
                    r_w[15] <= w_w_new;
                    if (r_cnt == 7'd63) begin
                        r_cnt   <= '0;
                        r_state <= ST_ADD;
                    end else begin
                        r_cnt <= r_cnt + 7'd1;
                    end
                end
                ST_ADD: begin
                    for (int i = 0; i < 8; i++) begin
                        r_hv[i] <= w_h_sum[i];
                        r_wv[i] <= w_h_sum[i];
                    end
                    r_cnt <= '0;
                    if (r_blk == r_last_blk) begin
                        r_mem_we    <= 1'b1;
                        r_mem_addr  <= r_hash_addr;
                        r_mem_wdata <= w_h_sum[0];
                        r_state     <= ST_WRITE;
                    end else begin
                        r_blk <= r_blk + BLK_W'(1);
                        if (w_g_rd_blk < G_W'(r_n))
                            r_mem_addr <= r_in_addr + ADDR_W'(w_g_rd_blk);
                        r_state <= ST_LOAD;
                    end
                end
                ST_WRITE: begin
                    if (r_cnt == 7'd7) begin
                        r_mem_we <= 1'b0;
                        r_done   <= 1'b1;
                        r_digest <= {r_hv[0], r_hv[1], r_hv[2], r_hv[3],
                                     r_hv[4], r_hv[5], r_hv[6], r_hv[7]};
                        r_cnt    <= '0;
                        r_state  <= ST_IDLE;
                    end else begin
                        r_mem_addr  <= r_hash_addr + ADDR_W'(r_cnt + 7'd1);
                        r_mem_wdata <= r_hv[3'(r_cnt + 7'd1)];
                        r_cnt       <= r_cnt + 7'd1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign mem_addr  = r_mem_addr;
    assign mem_we    = r_mem_we;
    assign mem_wdata = r_mem_wdata;
    assign busy      = (r_state != ST_IDLE);
    assign done      = r_done;
    assign digest    = r_digest;

endmodule

// File: tb/tb_sha256_mem_engine.sv
// Random-stimulus bench for sha256_mem_engine against a plain SHA-256 reference
// built from a padded word queue and a full 64-entry message schedule.
module tb_sha256_mem_engine;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [10:0]  msg_words;
    logic [15:0]  input_addr, hash_addr;
    logic [15:0]  mem_addr;
    logic         mem_we;
    logic [31:0]  mem_wdata;
    logic [31:0]  mem_rdata;
    logic         busy, done;
    logic [255:0] digest;

    logic [31:0]  mem [0:65535];
    logic [15:0]  wr_addr_log [0:1023];
    logic [31:0]  wr_data_log [0:1023];
    int           wr_total = 0;

    int           n_chk = 0;
    int           n_err = 0;

    sha256_mem_engine #(.ADDR_W(16), .MAX_WORDS(1024)) dut (
        .clk(clk), .rst(rst), .start(start), .msg_words(msg_words),
        .input_addr(input_addr), .hash_addr(hash_addr),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy), .done(done), .digest(digest)
    );

    always #5 clk = ~clk;

    // Read port only; digest writes are logged rather than stored
    always @(posedge clk) begin
        mem_rdata <= mem[mem_addr];
        if (mem_we) begin
            wr_addr_log[wr_total[9:0]] <= mem_addr;
            wr_data_log[wr_total[9:0]] <= mem_wdata;
            wr_total <= wr_total + 1;
        end
    end

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] x, input int s);
        return (x >> s) | (x << (32 - s));
    endfunction

    function automatic logic [255:0] sha_ref(input int n, input logic [15:0] ia);
        logic [31:0] q[$];
        logic [31:0] w[64];
        logic [31:0] h[8];
        logic [31:0] a, b, c, d, e, f, g, hh, t1, t2;
        h = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
              32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
        for (int i = 0; i < n; i++) q.push_back(mem[16'(ia + i)]);
        q.push_back(32'h8000_0000);
        while (q.size() % 16 != 14) q.push_back(32'd0);
        q.push_back(32'd0);
        q.push_back(32'(n * 32));
        for (int blk = 0; blk < q.size() / 16; blk++) begin
            for (int t = 0; t < 64; t++) begin
                if (t < 16) w[t] = q[blk*16 + t];
                else w[t] = (rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
                          + (rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
            end
            a = h[0]; b = h[1]; c = h[2]; d = h[3]; e = h[4]; f = h[5]; g = h[6]; hh = h[7];
            for (int t = 0; t < 64; t++) begin
                t1 = hh + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g))
                   + sha256_pkg::K[t] + w[t];
                t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
                hh = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
            end
            h[0] += a; h[1] += b; h[2] += c; h[3] += d;
            h[4] += e; h[5] += f; h[6] += g; h[7] += hh;
        end
        return {h[0], h[1], h[2], h[3], h[4], h[5], h[6], h[7]};
    endfunction

    task automatic do_op(input int n_in, input logic [15:0] ia, input logic [15:0] ha,
                         input bit spam, input string tag);
        int           n_eff, nb, lat, wr0, rd_bad, exp_lat;
        bit           saw_last;
        logic [255:0] exp_d;
        logic [15:0]  prev_addr, off, last_rd;
        logic [127:0] got_a, exp_a;
        n_eff   = (n_in > 1024) ? 1024 : n_in;
        exp_d   = sha_ref(n_eff, ia);
        nb      = (n_eff + 3 + 15) / 16;
        exp_lat = 82 * nb + 9;
        last_rd = 16'(ia + n_eff - 1);
        @(negedge clk);
        prev_addr = mem_addr;
        wr0 = wr_total;
        start = 1'b1; msg_words = 11'(n_in); input_addr = ia; hash_addr = ha;
        lat = 0; rd_bad = 0; saw_last = 1'b0;
        do begin
            @(posedge clk); #1;
            lat++;
            if (spam && lat < exp_lat - 20 && (lat % 7) == 3) begin
                start = 1'b1;
                msg_words = 11'($urandom_range(0, 40));
                input_addr = 16'($urandom);
                hash_addr = 16'($urandom);
            end else begin
                start = 1'b0;
            end
            if (lat == 1) check({tag, " busy_after_start"}, busy, 1);
            if (busy && !mem_we) begin
                off = mem_addr - ia;
                if (n_eff == 0) begin
                    if (mem_addr != prev_addr) rd_bad++;
                end else if (int'(off) >= n_eff) begin
                    rd_bad++;
                end
                if (n_eff > 0 && mem_addr == last_rd) saw_last = 1'b1;
            end
        end while (!done && lat < exp_lat + 20);
        check({tag, " latency"}, lat, exp_lat);
        check({tag, " digest"}, digest, exp_d);
        check({tag, " busy_at_done"}, busy, 0);
        check({tag, " read_range"}, rd_bad, 0);
        if (n_eff > 0) check({tag, " last_read"}, saw_last, 1);
        check({tag, " write_count"}, wr_total - wr0, 8);
        got_a = '0; exp_a = '0;
        for (int k = 0; k < 8; k++) begin
            got_a = {got_a[111:0], wr_addr_log[10'(wr0 + k)]};
            exp_a = {exp_a[111:0], 16'(ha + k)};
            check({tag, " wdata"}, wr_data_log[10'(wr0 + k)], exp_d[255 - 32*k -: 32]);
        end
        check({tag, " waddr"}, got_a, exp_a);
        repeat (3) @(posedge clk);
        #1;
        check({tag, " done_one_cycle"}, done, 0);
        check({tag, " digest_hold"}, digest, exp_d);
        check({tag, " idle_after"}, busy, 0);
        $display("op %s: n=%0d in=%h out=%h lat=%0d digest=%h", tag, n_in, ia, ha, lat, digest);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; msg_words = '0; input_addr = '0; hash_addr = '0;
        for (int i = 0; i < 65536; i++) mem[i] = $urandom;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset mem_we", mem_we, 0);
        check("reset mem_addr", mem_addr, 0);
        check("reset digest", digest, 0);
        rst = 1'b0;

        do_op(0, 16'h0100, 16'h8000, 1'b0, "empty");
        check("empty kat", digest,
              256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855);

        mem[16'h0200] = 32'h61626364;
        do_op(1, 16'h0200, 16'h8100, 1'b0, "abcd");
        check("abcd kat", digest,
              256'h88d4266fd4e6338d13b845fcf289579d209c897823b9217da3e161936f031589);

        do_op(13, 16'h0300, 16'h8200, 1'b0, "n13");
        do_op(14, 16'h0400, 16'h8300, 1'b0, "n14");
        do_op(5, 16'h0500, 16'h8400, 1'b1, "spam");
        do_op(16, 16'hFFF8, 16'h8500, 1'b0, "wrap");

        for (int r = 0; r < 4; r++)
            do_op($urandom_range(0, 40), 16'($urandom_range(0, 16'h7000)),
                  16'($urandom_range(16'h8000, 16'hF000)), 1'b0, "rand");

        do_op(2000, 16'h1000, 16'h9000, 1'b0, "clamp");

        // Abort in the middle of block 2's rounds, then rerun from scratch
        @(negedge clk);
        start = 1'b1; msg_words = 11'd20; input_addr = 16'h2000; hash_addr = 16'h9100;
        for (int i = 0; i < 120; i++) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        check("midop busy", busy, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst busy", busy, 0);
        check("rst mem_we", mem_we, 0);
        check("rst done", done, 0);
        check("rst mem_addr", mem_addr, 0);
        check("rst mem_wdata", mem_wdata, 0);
        check("rst digest", digest, 0);
        rst = 1'b0;
        do_op(20, 16'h2000, 16'h9100, 1'b0, "after_rst");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
